// File: rtl/fetch_bundle_builder.sv
// Packs sequential fetched instruction words into bundles of up to four slots.
// Optional idle-timeout close of partial bundles is built when BUNDLE_TIMEOUT_EN is defined.
module fetch_bundle_builder #(
    parameter int addressWidth            = 64,
    parameter int instructionWidth        = 32,
    parameter int bundleSize              = 4 * instructionWidth,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int instructionCounterWidth = 64,
    parameter int FlushTimeout            = 4
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               instrValid_i,
    input  logic [instructionWidth-1:0]        instr_i,
    input  logic [addressWidth-1:0]            instrAddr_i,
    input  logic [PidSize-1:0]                 pid_i,
    input  logic [TidSize-1:0]                 tid_i,
    input  logic                               flush_i,
    input  logic                               stall_i,
    output logic                               ready_o,
    output logic                               bundleValid_o,
    output logic [bundleSize-1:0]              bundle_o,
    output logic [addressWidth-1:0]            bundleAddress_o,
    output logic [1:0]                         bundleLen_o,
    output logic [PidSize-1:0]                 bundlePid_o,
    output logic [TidSize-1:0]                 bundleTid_o,
    output logic [instructionCounterWidth-1:0] bundleStartMajId_o
);

    localparam int SLOTS = 4;

    typedef enum logic {
        EMPTY,
        FILLING
    } acc_state_t;

    acc_state_t                         state;
    logic [instructionWidth-1:0]        slot_q [SLOTS];
    logic [2:0]                         count_q;
    logic [addressWidth-1:0]            start_addr_q;
    logic [addressWidth-1:0]            last_addr_q;
    logic [PidSize-1:0]                 pid_q;
    logic [TidSize-1:0]                 tid_q;
    logic [instructionCounterWidth-1:0] maj_id_q;

    logic                    accept;
    logic                    contiguous;
    logic                    line_end;
    logic                    break_close;
    logic                    append_close;
    logic                    timeout_close;
    logic                    close_bundle;
    logic                    from_input;
    logic [bundleSize-1:0]   emit_bundle;
    logic [1:0]              emit_len;
    logic [addressWidth-1:0] emit_addr;
    logic [PidSize-1:0]      emit_pid;
    logic [TidSize-1:0]      emit_tid;

    assign ready_o = !stall_i && !reset_i && !flush_i;
    assign accept  = instrValid_i && ready_o;

    // A word continues the bundle only if it is the next sequential word of the same thread.
    assign contiguous = (instrAddr_i == last_addr_q + addressWidth'(4))
                     && (pid_i == pid_q) && (tid_i == tid_q);
    // Word index bits [5:2] all ones marks the final word of a 64-byte line.
    assign line_end   = (instrAddr_i[5:2] == 4'b1111);

    assign break_close  = accept && (state == FILLING) && !contiguous;
    assign append_close = accept && !break_close
                       && ((count_q == 3'd3) || line_end);
    assign close_bundle = break_close || append_close || timeout_close;

    // A bundle closed by its very first word takes address and thread from the inputs.
    assign from_input = (state == EMPTY);
    assign emit_addr  = from_input ? instrAddr_i : start_addr_q;
    assign emit_pid   = from_input ? pid_i : pid_q;
    assign emit_tid   = from_input ? tid_i : tid_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        emit_bundle = '0;
        emit_len    = 2'(count_q - 3'd1);
        if (append_close) begin
            emit_len = 2'(count_q);
        end
        for (int n = 0; n < SLOTS; n++) begin
            if (3'(n) < count_q) begin
                emit_bundle[n*instructionWidth +: instructionWidth] = slot_q[n];
            end else if (append_close && (3'(n) == count_q)) begin
                emit_bundle[n*instructionWidth +: instructionWidth] = instr_i;
            end
        end
    end

`ifdef BUNDLE_TIMEOUT_EN
    localparam int IDLE_W = $clog2(FlushTimeout + 1);

    logic [IDLE_W-1:0] idle_q;

    assign timeout_close = !reset_i && !flush_i && !stall_i && !accept
                        && (state == FILLING)
                        && (32'(idle_q) + 1 == FlushTimeout);

    always_ff @(posedge clock_i) begin
        if (reset_i || flush_i) begin
            idle_q <= '0;
        end else if (!stall_i) begin
            if (accept || close_bundle || (state == EMPTY)) begin
                idle_q <= '0;
            end else begin
                idle_q <= idle_q + 1'b1;
            end
        end
    end
`else
    // Partial bundles never time out in this build.
    assign timeout_close = (FlushTimeout < 0);
`endif

    // NOTE: slot storage carries no reset; slots beyond count_q are masked to zero on emit.
    always_ff @(posedge clock_i) begin
        if (accept) begin
            slot_q[break_close ? 2'd0 : count_q[1:0]] <= instr_i;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state              <= EMPTY;
            count_q            <= '0;
            start_addr_q       <= '0;
            last_addr_q        <= '0;
            pid_q              <= '0;
            tid_q              <= '0;
            maj_id_q           <= '0;
            bundleValid_o      <= 1'b0;
            bundle_o           <= '0;
            bundleAddress_o    <= '0;
            bundleLen_o        <= '0;
            bundlePid_o        <= '0;
            bundleTid_o        <= '0;
            bundleStartMajId_o <= '0;
        end else begin
            bundleValid_o <= 1'b0;
            if (flush_i) begin
                state   <= EMPTY;
                count_q <= '0;
            end else if (!stall_i) begin
                if (close_bundle) begin
                    bundleValid_o      <= 1'b1;
                    bundle_o           <= emit_bundle;
                    bundleAddress_o    <= emit_addr;
                    bundleLen_o        <= emit_len;
                    bundlePid_o        <= emit_pid;
                    bundleTid_o        <= emit_tid;
                    bundleStartMajId_o <= maj_id_q;
                    maj_id_q           <= maj_id_q + instructionCounterWidth'(emit_len)
                                        + instructionCounterWidth'(1);
                end
                if (accept) begin
                    last_addr_q <= instrAddr_i;
                    if (append_close) begin
                        state   <= EMPTY;
                        count_q <= '0;
                    end else if (break_close || (state == EMPTY)) begin
                        state        <= FILLING;
                        count_q      <= 3'd1;
                        start_addr_q <= instrAddr_i;
                        pid_q        <= pid_i;
                        tid_q        <= tid_i;
                    end else begin
                        count_q <= count_q + 3'd1;
                    end
                end else if (timeout_close) begin
                    state   <= EMPTY;
                    count_q <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_bundle_builder.sv
// Bench for fetch_bundle_builder: directed vector table, hand sequences, and a randomized
// run checked every cycle against a queue-based bundle model.
module tb_fetch_bundle_builder;

    localparam int AW = 64;
    localparam int IW = 32;
    localparam int BW = 4 * IW;
    localparam int PW = 20;
    localparam int TW = 16;
    localparam int CW = 64;
    localparam int FT = 4;
`ifdef BUNDLE_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          clock_i = 1'b0;
    logic          reset_i = 1'b1;
    logic          instrValid_i = 1'b0;
    logic [IW-1:0] instr_i = '0;
    logic [AW-1:0] instrAddr_i = '0;
    logic [PW-1:0] pid_i = 20'h12345;
    logic [TW-1:0] tid_i = 16'hBEEF;
    logic          flush_i = 1'b0;
    logic          stall_i = 1'b0;
    logic          ready_o;
    logic          bundleValid_o;
    logic [BW-1:0] bundle_o;
    logic [AW-1:0] bundleAddress_o;
    logic [1:0]    bundleLen_o;
    logic [PW-1:0] bundlePid_o;
    logic [TW-1:0] bundleTid_o;
    logic [CW-1:0] bundleStartMajId_o;

    always #5 clock_i = ~clock_i;

    fetch_bundle_builder #(
        .addressWidth(AW), .instructionWidth(IW), .bundleSize(BW), .PidSize(PW),
        .TidSize(TW), .instructionCounterWidth(CW), .FlushTimeout(FT)
    ) dut (
        .clock_i(clock_i), .reset_i(reset_i), .instrValid_i(instrValid_i),
        .instr_i(instr_i), .instrAddr_i(instrAddr_i), .pid_i(pid_i), .tid_i(tid_i),
        .flush_i(flush_i), .stall_i(stall_i), .ready_o(ready_o),
        .bundleValid_o(bundleValid_o), .bundle_o(bundle_o),
        .bundleAddress_o(bundleAddress_o), .bundleLen_o(bundleLen_o),
        .bundlePid_o(bundlePid_o), .bundleTid_o(bundleTid_o),
        .bundleStartMajId_o(bundleStartMajId_o)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [IW-1:0] instr;
        logic [AW-1:0] addr;
    } word_t;

    word_t         acc[$];
    logic [PW-1:0] m_pid;
    logic [TW-1:0] m_tid;
    logic [CW-1:0] m_maj = '0;
    int            m_idle = 0;
    logic          e_valid = 1'b0;
    logic [BW-1:0] e_bundle = '0;
    logic [AW-1:0] e_addr = '0;
    logic [1:0]    e_len = '0;
    logic [PW-1:0] e_pid = '0;
    logic [TW-1:0] e_tid = '0;
    logic [CW-1:0] e_maj = '0;

    task automatic m_emit();
        e_valid  = 1'b1;
        e_bundle = '0;
        foreach (acc[i]) e_bundle[i*IW +: IW] = acc[i].instr;
        e_addr = acc[0].addr;
        e_len  = 2'(acc.size() - 1);
        e_pid  = m_pid;
        e_tid  = m_tid;
        e_maj  = m_maj;
        m_maj  = m_maj + CW'(acc.size());
        acc.delete();
    endtask

    task automatic model_edge();
        word_t w;
        e_valid = 1'b0;
        if (reset_i) begin
            acc.delete();
            m_maj = '0; m_idle = 0;
            e_bundle = '0; e_addr = '0; e_len = '0; e_pid = '0; e_tid = '0; e_maj = '0;
        end else if (flush_i) begin
            acc.delete();
            m_idle = 0;
        end else if (!stall_i) begin
            if (instrValid_i) begin
                w.instr = instr_i;
                w.addr  = instrAddr_i;
                m_idle  = 0;
                if (acc.size() > 0 && (instrAddr_i != acc[$].addr + 4
                                       || pid_i != m_pid || tid_i != m_tid)) begin
                    m_emit();
                    acc.push_back(w);
                    m_pid = pid_i;
                    m_tid = tid_i;
                end else begin
                    if (acc.size() == 0) begin
                        m_pid = pid_i;
                        m_tid = tid_i;
                    end
                    acc.push_back(w);
                    if (acc.size() == 4 || instrAddr_i[5:2] == 4'hF) m_emit();
                end
            end else if (TMO_EN && acc.size() > 0) begin
                m_idle++;
                if (m_idle == FT) begin
                    m_emit();
                    m_idle = 0;
                end
            end
        end
    endtask

    function automatic logic [IW-1:0] mk_instr(input logic [AW-1:0] a);
        return a[IW-1:0] ^ 32'hC0DE_0000;
    endfunction

    // Apply one cycle of inputs, check ready, clock, then compare every output to the model.
    task automatic cycle(input logic rst, input logic vld, input logic [AW-1:0] addr,
                         input logic [IW-1:0] ins, input logic fl, input logic st);
        reset_i = rst; instrValid_i = vld; instrAddr_i = addr; instr_i = ins;
        flush_i = fl; stall_i = st;
        #1;
        check("ready", ready_o, !st && !rst && !fl);
        model_edge();
        @(posedge clock_i);
        #1;
        check("bundleValid", bundleValid_o, e_valid);
        check("bundle", bundle_o, e_bundle);
        check("bundleAddress", bundleAddress_o, e_addr);
        check("bundleLen", bundleLen_o, e_len);
        check("bundlePid", bundlePid_o, e_pid);
        check("bundleTid", bundleTid_o, e_tid);
        check("bundleStartMajId", bundleStartMajId_o, e_maj);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          rst, vld, fl, st;
        logic [AW-1:0] addr;
        logic          exp_valid;
        logic [1:0]    exp_len;
        logic [AW-1:0] exp_addr;
        logic [CW-1:0] exp_maj;
        logic          exp_hi_zero;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic rst, input logic vld, input logic [AW-1:0] addr,
                           input logic fl, input logic st, input logic ev, input logic [1:0] el,
                           input logic [AW-1:0] ea, input logic [CW-1:0] em, input logic hz);
        vec_t v;
        v.rst = rst; v.vld = vld; v.addr = addr; v.fl = fl; v.st = st;
        v.exp_valid = ev; v.exp_len = el; v.exp_addr = ea; v.exp_maj = em; v.exp_hi_zero = hz;
        vecs.push_back(v);
    endtask

    initial begin
        logic [AW-1:0] seq_addr;
        logic          r_rst, r_fl, r_st, r_vld;

        add_vec(1, 0, 64'h0,    0, 0, 0, 0, 0, 0, 0);
        add_vec(1, 0, 64'h0,    0, 0, 0, 0, 0, 0, 0);
        add_vec(0, 1, 64'h1000, 0, 0, 0, 0, 0, 0, 0);
        add_vec(0, 1, 64'h1004, 0, 0, 0, 0, 0, 0, 0);
        add_vec(0, 1, 64'h1008, 0, 0, 0, 0, 0, 0, 0);
        add_vec(0, 1, 64'h100C, 0, 0, 1, 3, 64'h1000, 0, 0);
        add_vec(0, 0, 64'h0,    0, 0, 0, 0, 0, 0, 0);
        add_vec(0, 1, 64'h1030, 0, 0, 0, 0, 0, 0, 0);
        add_vec(0, 1, 64'h1034, 0, 0, 0, 0, 0, 0, 0);
        add_vec(0, 1, 64'h2000, 0, 0, 1, 1, 64'h1030, 4, 0);
        add_vec(0, 1, 64'h1038, 0, 0, 1, 0, 64'h2000, 6, 0);
        add_vec(0, 1, 64'h103C, 0, 0, 1, 1, 64'h1038, 7, 1);
        add_vec(0, 1, 64'h4000, 0, 0, 0, 0, 0, 0, 0);
        add_vec(0, 1, 64'h4004, 0, 0, 0, 0, 0, 0, 0);
        add_vec(0, 1, 64'h4008, 1, 0, 0, 0, 0, 0, 0);
        add_vec(0, 0, 64'h0,    0, 0, 0, 0, 0, 0, 0);
        add_vec(0, 1, 64'h5000, 0, 0, 0, 0, 0, 0, 0);
        add_vec(0, 1, 64'h5004, 0, 0, 0, 0, 0, 0, 0);
        add_vec(0, 1, 64'h5008, 0, 0, 0, 0, 0, 0, 0);
        add_vec(0, 1, 64'h500C, 0, 0, 1, 3, 64'h5000, 9, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].rst, vecs[i].vld, vecs[i].addr, mk_instr(vecs[i].addr),
                  vecs[i].fl, vecs[i].st);
            check("tbl_valid", bundleValid_o, vecs[i].exp_valid);
            if (vecs[i].exp_valid) begin
                check("tbl_len", bundleLen_o, vecs[i].exp_len);
                check("tbl_addr", bundleAddress_o, vecs[i].exp_addr);
                check("tbl_majid", bundleStartMajId_o, vecs[i].exp_maj);
            end
            if (vecs[i].exp_hi_zero) check("tbl_slots23_zero", bundle_o[BW-1:2*IW], '0);
        end

        // Stall holding one word: no acceptance, no emission.
        cycle(0, 1, 64'h6000, mk_instr(64'h6000), 0, 0);
        for (int i = 0; i < 10; i++) begin
            cycle(0, 1, 64'h6004, mk_instr(64'h6004), 0, 1);
            check("stall_ready", ready_o, 1'b0);
            check("stall_no_emit", bundleValid_o, 1'b0);
        end
`ifdef BUNDLE_TIMEOUT_EN
        for (int i = 0; i < FT - 1; i++) begin
            cycle(0, 0, 64'h0, 32'h0, 0, 0);
            check("tmo_wait", bundleValid_o, 1'b0);
        end
        cycle(0, 0, 64'h0, 32'h0, 0, 0);
        check("tmo_emit", bundleValid_o, 1'b1);
        check("tmo_len", bundleLen_o, 2'd0);
        check("tmo_addr", bundleAddress_o, 64'h6000);
        check("tmo_majid", bundleStartMajId_o, 64'd13);
        cycle(0, 1, 64'h7000, mk_instr(64'h7000), 0, 0);
        check("tmo_fresh_no_emit", bundleValid_o, 1'b0);
`else
        for (int i = 0; i < 6; i++) begin
            cycle(0, 0, 64'h0, 32'h0, 0, 0);
            check("no_tmo_idle", bundleValid_o, 1'b0);
        end
        cycle(0, 1, 64'h7000, mk_instr(64'h7000), 0, 0);
        check("break_emit", bundleValid_o, 1'b1);
        check("break_len", bundleLen_o, 2'd0);
        check("break_addr", bundleAddress_o, 64'h6000);
        check("break_majid", bundleStartMajId_o, 64'd13);
`endif
        cycle(0, 1, 64'h7004, mk_instr(64'h7004), 0, 0);
        cycle(0, 1, 64'h7008, mk_instr(64'h7008), 0, 0);

        // Reset with three words held and stall asserted.
        cycle(1, 1, 64'h700C, mk_instr(64'h700C), 0, 1);
        check("rst_valid", bundleValid_o, 1'b0);
        check("rst_bundle", bundle_o, '0);
        check("rst_addr", bundleAddress_o, '0);
        check("rst_len", bundleLen_o, '0);
        check("rst_pid", bundlePid_o, '0);
        check("rst_tid", bundleTid_o, '0);
        check("rst_majid", bundleStartMajId_o, '0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 64'h8000 + AW'(4 * i), mk_instr(64'h8000 + AW'(4 * i)), 0, 0);
        end
        check("post_rst_emit", bundleValid_o, 1'b1);
        check("post_rst_addr", bundleAddress_o, 64'h8000);
        check("post_rst_majid", bundleStartMajId_o, 64'd0);

        // Randomized traffic against the model.
        seq_addr = 64'h9000;
        for (int i = 0; i < 3000; i++) begin
            r_rst = ($urandom_range(0, 199) == 0);
            r_fl  = ($urandom_range(0, 99) < 4);
            r_st  = ($urandom_range(0, 99) < 20);
            r_vld = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 99) < 12) seq_addr = AW'($urandom_range(0, 1023)) << 2;
            if ($urandom_range(0, 99) < 3) pid_i = PW'($urandom_range(0, 1));
            if ($urandom_range(0, 99) < 3) tid_i = TW'($urandom_range(0, 1));
            cycle(r_rst, r_vld, seq_addr, $urandom, r_fl, r_st);
            if (r_vld) seq_addr = seq_addr + 4;
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
